// File: rtl/instr_encode_loader_if.sv
// Request, memory-write and status bundle for the instruction encoder/loader.
// The master drives encode requests; the slave (the loader) drives the write port and status.
interface instr_encode_loader_if #(
    parameter int ADDR_W = 10
);
    logic              start;
    logic              in_valid;
    logic              in_ready;
    logic [4:0]        in_kind;
    logic [4:0]        rs;
    logic [4:0]        rt;
    logic [4:0]        rd;
    logic [4:0]        shamt;
    logic [15:0]       imm;
    logic [25:0]       target;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W:0]   count;
    logic              full;
    logic              busy;
    logic              err_illegal;
    logic [31:0]       checksum;

    modport master (
        output start, in_valid, in_kind, rs, rt, rd, shamt, imm, target,
        input  in_ready, mem_we, mem_addr, mem_wdata, count, full, busy,
               err_illegal, checksum
    );

    modport slave (
        input  start, in_valid, in_kind, rs, rt, rd, shamt, imm, target,
        output in_ready, mem_we, mem_addr, mem_wdata, count, full, busy,
               err_illegal, checksum
    );
endinterface

// File: rtl/instr_encode_loader.sv
// Encodes MIPS-style instruction requests into 32-bit words and streams them
// sequentially into instruction memory, tracking word count and an XOR checksum.
module instr_encode_loader #(
    parameter int ADDR_W = 10
) (
    input logic                  clock,
    input logic                  reset_n,
    instr_encode_loader_if.slave bus
);
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] WRITE = 1'b1;

    logic [0:0]        state_q, state_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [31:0]       checksum_q, checksum_d;
    logic              err_illegal_q, err_illegal_d;

    logic [31:0] word;
    logic        legal;
    logic        full;
    logic        in_ready;
    logic        accept;

    assign full     = (count_q == DEPTH_CNT);
    assign in_ready = (state_q == IDLE) && !full && !bus.start;
    assign accept   = bus.in_valid && in_ready;

    // Field forcing (zeroed rs/rt/rd/shamt) is folded into each format here.
    always_comb begin
        word  = 32'h0;
        legal = 1'b1;
        case (bus.in_kind)
            5'd0:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100000};
            5'd1:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100010};
            5'd2:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100100};
            5'd3:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b100101};
            5'd4:  word = {6'b000000, bus.rs, bus.rt, bus.rd, 5'd0, 6'b101010};
            5'd5:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000000};
            5'd6:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000010};
            5'd7:  word = {6'b000000, 5'd0, bus.rt, bus.rd, bus.shamt, 6'b000011};
            5'd8:  word = {6'b000000, bus.rs, 15'd0, 6'b001000};
            5'd9:  word = {6'b001000, bus.rs, bus.rt, bus.imm};
            5'd10: word = {6'b001101, bus.rs, bus.rt, bus.imm};
            5'd11: word = {6'b100011, bus.rs, bus.rt, bus.imm};
            5'd12: word = {6'b101011, bus.rs, bus.rt, bus.imm};
            5'd13: word = {6'b000100, bus.rs, bus.rt, bus.imm};
            5'd14: word = {6'b000101, bus.rs, bus.rt, bus.imm};
            5'd15: word = {6'b000010, bus.target};
            5'd16: word = {6'b000011, bus.target};
            5'd17: word = {6'b001111, 5'd0, bus.rt, bus.imm};
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        wr_ptr_d      = wr_ptr_q;
        count_d       = count_q;
        checksum_d    = checksum_q;
        err_illegal_d = err_illegal_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    wr_ptr_d      = '0;
                    count_d       = '0;
                    checksum_d    = 32'h0;
                    err_illegal_d = 1'b0;
                end else if (accept) begin
                    if (legal) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = wr_ptr_q;
                        mem_wdata_d = word;
                        state_d     = WRITE;
                    end else begin
                        err_illegal_d = 1'b1;
                    end
                end
            end
            WRITE: begin
                state_d = IDLE;
                // A start arriving mid-write lets the write land but wipes its bookkeeping.
                if (bus.start) begin
                    wr_ptr_d      = '0;
                    count_d       = '0;
                    checksum_d    = 32'h0;
                    err_illegal_d = 1'b0;
                end else begin
                    if (wr_ptr_q != {ADDR_W{1'b1}}) begin
                        wr_ptr_d = wr_ptr_q + 1'b1;
                    end
                    count_d    = count_q + 1'b1;
                    checksum_d = checksum_q ^ mem_wdata_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 32'h0;
            wr_ptr_q      <= '0;
            count_q       <= '0;
            checksum_q    <= 32'h0;
            err_illegal_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            wr_ptr_q      <= wr_ptr_d;
            count_q       <= count_d;
            checksum_q    <= checksum_d;
            err_illegal_q <= err_illegal_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_we      = mem_we_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wdata   = mem_wdata_q;
    assign bus.count       = count_q;
    assign bus.full        = full;
    assign bus.busy        = (state_q == WRITE);
    assign bus.err_illegal = err_illegal_q;
    assign bus.checksum    = checksum_q;
endmodule

// File: tb/tb_instr_encode_loader.sv
// Directed bench for instr_encode_loader: a default-depth instance for encoding and
// session control, and a 4-word instance for the full/no-wrap behaviour.
module tb_instr_encode_loader;
    logic clock;
    logic reset_n;

    int check_count;
    int pass_count;
    int write_count;

    instr_encode_loader_if #(.ADDR_W(10)) bus ();
    instr_encode_loader_if #(.ADDR_W(2))  bus_s ();

    instr_encode_loader #(.ADDR_W(10)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    instr_encode_loader #(.ADDR_W(2)) dut_s (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus_s.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    endtask

    // Presents one request for a single cycle; returns just after the accept edge.
    task automatic applyStimulus(input logic [4:0] kind, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic [4:0] rd,
                                 input logic [4:0] shamt, input logic [15:0] imm,
                                 input logic [25:0] target);
        bus.in_kind  = kind;
        bus.rs       = rs;
        bus.rt       = rt;
        bus.rd       = rd;
        bus.shamt    = shamt;
        bus.imm      = imm;
        bus.target   = target;
        bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        write_count = 0;
        reset_n     = 1'b0;
        bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_kind = 5'd0;
        bus.rs = 5'd0; bus.rt = 5'd0; bus.rd = 5'd0; bus.shamt = 5'd0;
        bus.imm = 16'h0; bus.target = 26'h0;
        bus_s.start = 1'b0; bus_s.in_valid = 1'b0; bus_s.in_kind = 5'd0;
        bus_s.rs = 5'd0; bus_s.rt = 5'd0; bus_s.rd = 5'd0; bus_s.shamt = 5'd0;
        bus_s.imm = 16'h0; bus_s.target = 26'h0;

        #12;
        checkOutput("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("rst_count", {21'd0, bus.count}, 32'd0);
        checkOutput("rst_checksum", bus.checksum, 32'h0);
        checkOutput("rst_busy_full_err", {29'd0, bus.busy, bus.full, bus.err_illegal}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

        // ADD with shamt forced to zero; fields scrambled after accept must not matter
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd7, 16'h0, 26'h0);
        bus.rs = 5'd31; bus.rd = 5'd17; bus.in_kind = 5'd9;
        checkOutput("add_we", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("add_addr", {22'd0, bus.mem_addr}, 32'd0);
        checkOutput("add_wdata", bus.mem_wdata, 32'h00221820);
        checkOutput("add_busy_ready", {30'd0, bus.busy, bus.in_ready}, 32'b10);
        tick();
        checkOutput("add_we_low", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("add_count", {21'd0, bus.count}, 32'd1);
        checkOutput("add_checksum", bus.checksum, 32'h00221820);
        checkOutput("add_wdata_hold", bus.mem_wdata, 32'h00221820);

        bus.start = 1'b1;
        #1;
        checkOutput("start_blocks_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.start = 1'b0;
        checkOutput("start_count", {21'd0, bus.count}, 32'd0);

        // Four-word mixed-format program
        applyStimulus(5'd9, 5'd0, 5'd8, 5'd0, 5'd0, 16'h0005, 26'h0);
        checkOutput("seq0_addr", {22'd0, bus.mem_addr}, 32'd0);
        checkOutput("seq0_wdata", bus.mem_wdata, 32'h20080005);
        tick();
        applyStimulus(5'd5, 5'd9, 5'd1, 5'd2, 5'd4, 16'h0, 26'h0);
        checkOutput("seq1_addr", {22'd0, bus.mem_addr}, 32'd1);
        checkOutput("seq1_wdata", bus.mem_wdata, 32'h00011100);
        tick();
        applyStimulus(5'd15, 5'd0, 5'd0, 5'd0, 5'd0, 16'h0, 26'h10);
        checkOutput("seq2_addr", {22'd0, bus.mem_addr}, 32'd2);
        checkOutput("seq2_wdata", bus.mem_wdata, 32'h08000010);
        tick();
        applyStimulus(5'd13, 5'd1, 5'd2, 5'd0, 5'd0, 16'hFFFF, 26'h0);
        checkOutput("seq3_addr", {22'd0, bus.mem_addr}, 32'd3);
        checkOutput("seq3_wdata", bus.mem_wdata, 32'h1022FFFF);
        tick();
        checkOutput("seq_count", {21'd0, bus.count}, 32'd4);
        checkOutput("seq_checksum", bus.checksum, 32'h382BEEEA);

        // Illegal kind is swallowed, then a legal ORI still lands at word 0
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        applyStimulus(5'd20, 5'd1, 5'd2, 5'd3, 5'd0, 16'h1234, 26'h0);
        checkOutput("ill_err", {31'd0, bus.err_illegal}, 32'd1);
        checkOutput("ill_no_write", {30'd0, bus.mem_we, bus.busy}, 32'd0);
        checkOutput("ill_count", {21'd0, bus.count}, 32'd0);
        applyStimulus(5'd10, 5'd3, 5'd4, 5'd0, 5'd0, 16'h00FF, 26'h0);
        checkOutput("ori_addr", {22'd0, bus.mem_addr}, 32'd0);
        checkOutput("ori_wdata", bus.mem_wdata, 32'h346400FF);
        tick();
        checkOutput("ori_count", {21'd0, bus.count}, 32'd1);
        checkOutput("ill_err_sticky", {31'd0, bus.err_illegal}, 32'd1);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        checkOutput("start_clears_err", {31'd0, bus.err_illegal}, 32'd0);
        checkOutput("start_clears_count", {21'd0, bus.count}, 32'd0);

        // start and in_valid together in IDLE: start wins
        bus.in_kind = 5'd0; bus.rs = 5'd1; bus.rt = 5'd2; bus.rd = 5'd3;
        bus.start = 1'b1; bus.in_valid = 1'b1;
        #1;
        checkOutput("start_valid_ready", {31'd0, bus.in_ready}, 32'd0);
        tick();
        bus.start = 1'b0; bus.in_valid = 1'b0;
        checkOutput("start_valid_nowrite", {30'd0, bus.mem_we, bus.busy}, 32'd0);
        checkOutput("start_valid_count", {21'd0, bus.count}, 32'd0);

        // start during WRITE: write still happens, counters cleared afterwards
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        bus.start = 1'b1;
        checkOutput("startw_we", {31'd0, bus.mem_we}, 32'd1);
        checkOutput("startw_addr", {22'd0, bus.mem_addr}, 32'd1);
        tick();
        bus.start = 1'b0;
        checkOutput("startw_count", {21'd0, bus.count}, 32'd0);
        checkOutput("startw_checksum", bus.checksum, 32'h0);
        checkOutput("startw_idle", {30'd0, bus.mem_we, bus.busy}, 32'd0);

        // Reset mid-WRITE aborts asynchronously
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        tick();
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        checkOutput("midrst_pre_we", {31'd0, bus.mem_we}, 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        checkOutput("midrst_we", {31'd0, bus.mem_we}, 32'd0);
        checkOutput("midrst_addr", {22'd0, bus.mem_addr}, 32'd0);
        checkOutput("midrst_wdata", bus.mem_wdata, 32'h0);
        checkOutput("midrst_count", {21'd0, bus.count}, 32'd0);
        checkOutput("midrst_busy", {31'd0, bus.busy}, 32'd0);
        #3;
        reset_n = 1'b1;
        #1;
        checkOutput("midrst_ready", {31'd0, bus.in_ready}, 32'd1);
        applyStimulus(5'd0, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
        checkOutput("postrst_addr", {22'd0, bus.mem_addr}, 32'd0);
        checkOutput("postrst_wdata", bus.mem_wdata, 32'h00221820);
        tick();

        // Depth-4 instance with in_valid held: exactly four writes, then full
        bus_s.in_kind = 5'd0; bus_s.rs = 5'd1; bus_s.rt = 5'd2; bus_s.rd = 5'd3;
        bus_s.in_valid = 1'b1;
        for (int i = 0; i < 14; i++) begin
            tick();
            if (bus_s.mem_we) begin
                checkOutput("full_seq_addr", {30'd0, bus_s.mem_addr}, write_count);
                write_count++;
            end
        end
        checkOutput("full_writes", write_count, 32'd4);
        checkOutput("full_flag", {31'd0, bus_s.full}, 32'd1);
        checkOutput("full_ready", {31'd0, bus_s.in_ready}, 32'd0);
        checkOutput("full_count", {29'd0, bus_s.count}, 32'd4);
        checkOutput("full_we_low", {31'd0, bus_s.mem_we}, 32'd0);
        bus_s.in_valid = 1'b0;

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end
endmodule
